// File: rtl/player_input_conditioner.sv
// player_input_conditioner
// Multi-channel button/switch conditioner: a per-channel flip-flop synchroniser,
// a stability-counter debouncer, and registered press/release strobes.
// Optional feature macro: PLAYER_INPUT_AUTOREPEAT_EN adds auto-repeat press
// pulses while a button is held (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
module player_input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the logic below cannot honour.
  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("player_input_conditioner: illegal parameter value");
  end

  logic [CHANNELS-1:0] sync_chain [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_lvl;
  logic [CNT_W-1:0]    db_cnt     [CHANNELS];

  assign sync_lvl = sync_chain[SYNC_STAGES-1];

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
  localparam int REP_MAX_V = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W     = (REP_MAX_V > 1) ? $clog2(REP_MAX_V) : 1;
  localparam logic [REP_W-1:0] DELAY_MAX  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_MAX = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]    rep_cnt [CHANNELS];
  // rep_armed: the first (long) delay has elapsed, subsequent repeats use the period
  logic [CHANNELS-1:0] rep_armed;
`endif

  // Synchroniser chain: stage 0 samples the pins, each later stage the one before.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
    end else begin
      sync_chain[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
    end
  end

  // Per-channel debounce, level/pulse registers and (optionally) auto-repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_out     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int c = 0; c < CHANNELS; c++) db_cnt[c] <= '0;
`ifdef PLAYER_INPUT_AUTOREPEAT_EN
      rep_armed <= '0;
      for (int c = 0; c < CHANNELS; c++) rep_cnt[c] <= '0;
`endif
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        press_pulse[c]   <= 1'b0;
        release_pulse[c] <= 1'b0;

        // Any sample agreeing with the current level restarts the stability count.
        if (sync_lvl[c] == level_out[c]) begin
          db_cnt[c] <= '0;
        end else if (db_cnt[c] == CNT_MAX) begin
          level_out[c]     <= sync_lvl[c];
          db_cnt[c]        <= '0;
          press_pulse[c]   <= sync_lvl[c];
          release_pulse[c] <= ~sync_lvl[c];
        end else begin
          db_cnt[c] <= db_cnt[c] + CNT_W'(1);
        end

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
        // A level flip (press or release) restarts the repeat timing; while held,
        // count to the initial delay, then to the period, pulsing each time.
        if ((sync_lvl[c] != level_out[c]) && (db_cnt[c] == CNT_MAX)) begin
          rep_cnt[c]   <= '0;
          rep_armed[c] <= 1'b0;
        end else if (level_out[c]) begin
          if (rep_armed[c] ? (rep_cnt[c] == PERIOD_MAX) : (rep_cnt[c] == DELAY_MAX)) begin
            press_pulse[c] <= 1'b1;
            rep_cnt[c]     <= '0;
            rep_armed[c]   <= 1'b1;
          end else begin
            rep_cnt[c] <= rep_cnt[c] + REP_W'(1);
          end
        end else begin
          rep_cnt[c]   <= '0;
          rep_armed[c] <= 1'b0;
        end
`endif
      end
    end
  end

endmodule
